// File: rtl/sdram_pkg.sv
// sdram_pkg: shared scheduler state type and default SDRAM address/burst widths
package sdram_pkg;
  localparam int SDRAM_ADDR_W = 24;
  localparam int SDRAM_LEN_W = 10;
  typedef enum logic [1:0] {IDLE, REQ, BUSY} sched_state_t;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: request/ack pairs to sdram_controller plus one-hot FIFO mux selects
interface sdram_port_arbiter_if import sdram_pkg::*; #(
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int LEN_W = SDRAM_LEN_W
);
  logic sdram_wr_req;
  logic sdram_wr_ack;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic [LEN_W-1:0] sdram_wr_burst;
  logic [NUM_WR-1:0] wr_sel;
  logic sdram_rd_req;
  logic sdram_rd_ack;
  logic [ADDR_W-1:0] sdram_rd_addr;
  logic [LEN_W-1:0] sdram_rd_burst;
  logic [NUM_RD-1:0] rd_sel;
  modport master (
    output sdram_wr_req, sdram_wr_addr, sdram_wr_burst, wr_sel,
    output sdram_rd_req, sdram_rd_addr, sdram_rd_burst, rd_sel,
    input sdram_wr_ack, sdram_rd_ack
  );
  modport slave (
    input sdram_wr_req, sdram_wr_addr, sdram_wr_burst, wr_sel,
    input sdram_rd_req, sdram_rd_addr, sdram_rd_burst, rd_sel,
    output sdram_wr_ack, sdram_rd_ack
  );
endinterface

// File: rtl/sdram_chan_sched.sv
// sdram_chan_sched: round-robin grant, request FSM and wrapping per-channel address pointers for one port
module sdram_chan_sched import sdram_pkg::*; #(
  parameter int N = 2,
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int LEN_W = SDRAM_LEN_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [N-1:0] elig,
  input  logic [N-1:0] load,
  input  logic [N-1:0][ADDR_W-1:0] min_addr,
  input  logic [N-1:0][ADDR_W-1:0] max_addr,
  input  logic [N-1:0][LEN_W-1:0] len,
  input  logic ack,
  output logic req,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0] burst,
  output logic [N-1:0] sel
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  sched_state_t state, state_n;
  logic [IW-1:0] rr, g, gnt;
  logic found, done, ack_q;
  logic [N-1:0][ADDR_W-1:0] ptr;
  logic [ADDR_W:0] nxt, lst;
  logic [ADDR_W-1:0] adv;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
  // lowest eligible channel overall, overridden by the lowest one at or after rr
  always_comb begin
    found = 1'b0;
    gnt = rr;
    for (int c = N - 1; c >= 0; c--) if (elig[c]) begin found = 1'b1; gnt = IW'(c); end
    for (int c = N - 1; c >= 0; c--) if (elig[c] && c >= int'(rr)) gnt = IW'(c);
    done = state == BUSY && !ack && ack_q;
    state_n = state == IDLE ? (found ? REQ : IDLE) : state == REQ ? (ack ? BUSY : REQ) : (done ? IDLE : BUSY);
    nxt = {1'b0, ptr[g]} + (ADDR_W + 1)'(len[g]);
    lst = nxt + (ADDR_W + 1)'(len[g]) - (ADDR_W + 1)'(1);
    adv = lst > {1'b0, max_addr[g]} ? min_addr[g] : nxt[ADDR_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req <= 1'b0;
      addr <= '0;
      burst <= '0;
      sel <= '0;
      rr <= '0;
      g <= '0;
      ack_q <= 1'b0;
      ptr <= min_addr;
    end else begin
      ack_q <= ack;
      if (state == IDLE && found) begin
        req <= 1'b1;
        g <= gnt;
        addr <= ptr[gnt];
        burst <= len[gnt];
        sel <= N'(1) << gnt;
      end
      if (state == REQ && ack) req <= 1'b0;
      if (done) begin
        sel <= '0;
        rr <= g == IW'(N - 1) ? '0 : g + 1'b1;
      end
      // a held load beats the completion advance
      for (int i = 0; i < N; i++)
        if (load[i]) ptr[i] <= min_addr[i];
        else if (done && g == IW'(i)) ptr[i] <= adv;
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_cfg_chk
    assert property (@(posedge clk) disable iff (!rst_n) min_addr[i] <= max_addr[i] && len[i] != '0);
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: arbitrates per-channel write/read FIFOs onto the single SDRAM controller request pair
module sdram_port_arbiter import sdram_pkg::*; #(
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int LEN_W = SDRAM_LEN_W,
  parameter int LVL_W = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sdram_init_done,
  input  logic [NUM_WR*LVL_W-1:0] wr_level,
  input  logic [NUM_WR*ADDR_W-1:0] wr_min_addr,
  input  logic [NUM_WR*ADDR_W-1:0] wr_max_addr,
  input  logic [NUM_WR*LEN_W-1:0] wr_len,
  input  logic [NUM_WR-1:0] wr_load,
  input  logic [NUM_RD*LVL_W-1:0] rd_level,
  input  logic [NUM_RD-1:0] rd_valid,
  input  logic [NUM_RD*ADDR_W-1:0] rd_min_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_max_addr,
  input  logic [NUM_RD*LEN_W-1:0] rd_len,
  input  logic [NUM_RD-1:0] rd_load,
  sdram_port_arbiter_if.master bus
);
  logic [NUM_WR-1:0] wr_elig;
  logic [NUM_RD-1:0] rd_elig;
  // writes need a full burst buffered; reads need room for a full burst
  always_comb begin
    wr_elig = '0;
    rd_elig = '0;
    for (int i = 0; i < NUM_WR; i++)
      wr_elig[i] = sdram_init_done && !wr_load[i] && 32'(wr_level[i*LVL_W +: LVL_W]) >= 32'(wr_len[i*LEN_W +: LEN_W]);
    for (int i = 0; i < NUM_RD; i++)
      rd_elig[i] = sdram_init_done && rd_valid[i] && !rd_load[i] && 32'(rd_level[i*LVL_W +: LVL_W]) < 32'(rd_len[i*LEN_W +: LEN_W]);
  end
  sdram_chan_sched #(.N(NUM_WR), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr (
    .clk(clk), .rst_n(rst_n), .elig(wr_elig), .load(wr_load),
    .min_addr(wr_min_addr), .max_addr(wr_max_addr), .len(wr_len), .ack(bus.sdram_wr_ack),
    .req(bus.sdram_wr_req), .addr(bus.sdram_wr_addr), .burst(bus.sdram_wr_burst), .sel(bus.wr_sel)
  );
  sdram_chan_sched #(.N(NUM_RD), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd (
    .clk(clk), .rst_n(rst_n), .elig(rd_elig), .load(rd_load),
    .min_addr(rd_min_addr), .max_addr(rd_max_addr), .len(rd_len), .ack(bus.sdram_rd_ack),
    .req(bus.sdram_rd_req), .addr(bus.sdram_rd_addr), .burst(bus.sdram_rd_burst), .sel(bus.rd_sel)
  );
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: grant table, directed burst sequences and a randomized transaction-level model
module tb_sdram_port_arbiter;
  localparam int AW = 24;
  localparam int LW = 10;
  localparam int VW = 11;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic [2*VW-1:0] wr_level = '0, rd_level = '0;
  logic [2*AW-1:0] wr_min, wr_max, rd_min, rd_max;
  logic [2*LW-1:0] wr_len, rd_len;
  logic [1:0] wr_load = '0, rd_load = '0, rd_valid = '0;
  int checks = 0, errors = 0;
  int cmin[2][2], cmax[2][2], clen[2][2];
  int ptr[2][2], ph[2], gch[2], rrp[2], ea[2], eb[2], wt[2], hd[2];
  bit pa[2];

  typedef struct {
    logic init;
    logic [VW-1:0] wl0, wl1;
    logic [1:0] wload, rvalid;
    logic [VW-1:0] rl0, rl1;
    logic [1:0] exp_wsel;
    logic [AW-1:0] exp_waddr;
    logic [1:0] exp_rsel;
    logic [AW-1:0] exp_raddr;
  } vec_t;
  vec_t tbl[7];

  sdram_port_arbiter_if #(.NUM_WR(2), .NUM_RD(2), .ADDR_W(AW), .LEN_W(LW)) bus();

  sdram_port_arbiter #(.NUM_WR(2), .NUM_RD(2), .ADDR_W(AW), .LEN_W(LW), .LVL_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init),
    .wr_level(wr_level), .wr_min_addr(wr_min), .wr_max_addr(wr_max), .wr_len(wr_len), .wr_load(wr_load),
    .rd_level(rd_level), .rd_valid(rd_valid), .rd_min_addr(rd_min), .rd_max_addr(rd_max),
    .rd_len(rd_len), .rd_load(rd_load), .bus(bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < 2; i++) begin
      wr_min[i*AW +: AW] = AW'(cmin[0][i]);
      wr_max[i*AW +: AW] = AW'(cmax[0][i]);
      wr_len[i*LW +: LW] = LW'(clen[0][i]);
      rd_min[i*AW +: AW] = AW'(cmin[1][i]);
      rd_max[i*AW +: AW] = AW'(cmax[1][i]);
      rd_len[i*LW +: LW] = LW'(clen[1][i]);
    end
  endtask

  task automatic set_ack(input bit rd, input logic v);
    if (rd) bus.sdram_rd_ack = v;
    else bus.sdram_wr_ack = v;
  endtask

  function automatic logic [31:0] req_of(input bit rd);
    return rd ? 32'(bus.sdram_rd_req) : 32'(bus.sdram_wr_req);
  endfunction

  function automatic logic [31:0] sel_of(input bit rd);
    return rd ? 32'(bus.rd_sel) : 32'(bus.wr_sel);
  endfunction

  task automatic txn_start(input bit rd, input int ch, input int a, input int b);
    string p = rd ? "rd" : "wr";
    int n = 0;
    while (req_of(rd) != 1 && n < 20) begin
      tick();
      n++;
    end
    chk({p, "_req_seen"}, req_of(rd), 1);
    chk({p, "_sel"}, sel_of(rd), 32'(1) << ch);
    chk({p, "_addr"}, rd ? 32'(bus.sdram_rd_addr) : 32'(bus.sdram_wr_addr), a);
    chk({p, "_burst"}, rd ? 32'(bus.sdram_rd_burst) : 32'(bus.sdram_wr_burst), b);
  endtask

  task automatic txn_end(input bit rd);
    string p = rd ? "rd" : "wr";
    set_ack(rd, 1'b1);
    tick();
    chk({p, "_req_drop"}, req_of(rd), 0);
    set_ack(rd, 1'b0);
    tick();
    chk({p, "_sel_clear"}, sel_of(rd), 0);
  endtask

  task automatic txn(input bit rd, input int ch, input int a, input int b);
    txn_start(rd, ch, a, b);
    txn_end(rd);
  endtask

  task automatic rst_task();
    rst_n = 1'b0;
    set_ack(0, 1'b0);
    set_ack(1, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int pick(input bit [1:0] el, input int rr);
    for (int k = 0; k < 2; k++)
      if (el[(rr + k) % 2]) return (rr + k) % 2;
    return -1;
  endfunction

  function automatic bit [1:0] wel();
    bit [1:0] r;
    for (int i = 0; i < 2; i++) r[i] = init && !wr_load[i] && int'(wr_level[i*VW +: VW]) >= clen[0][i];
    return r;
  endfunction

  function automatic bit [1:0] rel();
    bit [1:0] r;
    for (int i = 0; i < 2; i++) r[i] = init && rd_valid[i] && !rd_load[i] && int'(rd_level[i*VW +: VW]) < clen[1][i];
    return r;
  endfunction

  // transaction-level view of one port, advanced once per clock edge from the inputs held across it
  task automatic model_side(input int s, input bit [1:0] el, input logic [1:0] ld, input logic a);
    if (ph[s] == 0) begin
      int c = pick(el, rrp[s]);
      if (c >= 0) begin
        gch[s] = c;
        ea[s] = ptr[s][c];
        eb[s] = clen[s][c];
        ph[s] = 1;
      end
    end else if (ph[s] == 1) begin
      if (a) ph[s] = 2;
    end else if (!a && pa[s]) begin
      int g = gch[s];
      ptr[s][g] = ptr[s][g] + 2 * clen[s][g] - 1 > cmax[s][g] ? cmin[s][g] : ptr[s][g] + clen[s][g];
      rrp[s] = (g + 1) % 2;
      ph[s] = 0;
    end
    pa[s] = a;
    for (int i = 0; i < 2; i++) if (ld[i]) ptr[s][i] = cmin[s][i];
  endtask

  task automatic drive_ack(input int s);
    logic a;
    if (ph[s] == 1) begin
      if (wt[s] > 0) begin
        wt[s]--;
        a = 1'b0;
      end else begin
        a = 1'b1;
        hd[s] = $urandom_range(0, 2);
      end
    end else if (ph[s] == 2) begin
      if (hd[s] > 0) begin
        hd[s]--;
        a = 1'b1;
      end else a = 1'b0;
    end else begin
      a = 1'b0;
      wt[s] = $urandom_range(0, 3);
    end
    set_ack(s[0], a);
  endtask

  task automatic rand_inputs();
    init = $urandom_range(0, 15) != 0;
    for (int i = 0; i < 2; i++) begin
      wr_level[i*VW +: VW] = VW'($urandom_range(0, 200));
      rd_level[i*VW +: VW] = VW'($urandom_range(0, 200));
      wr_load[i] = $urandom_range(0, 15) == 0;
      rd_load[i] = $urandom_range(0, 15) == 0;
      rd_valid[i] = $urandom_range(0, 3) != 0;
    end
  endtask

  task automatic check_side(input int s);
    string p = s == 1 ? "rnd_rd" : "rnd_wr";
    chk({p, "_req"}, req_of(s[0]), 32'(ph[s] == 1));
    chk({p, "_sel"}, sel_of(s[0]), ph[s] != 0 ? 32'(1) << gch[s] : 32'd0);
    if (ph[s] != 0) begin
      chk({p, "_addr"}, s == 1 ? 32'(bus.sdram_rd_addr) : 32'(bus.sdram_wr_addr), ea[s]);
      chk({p, "_burst"}, s == 1 ? 32'(bus.sdram_rd_burst) : 32'(bus.sdram_wr_burst), eb[s]);
    end
  endtask

  initial begin
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    cmin = '{'{0, 'h400}, '{'h800, 'hC00}};
    cmax = '{'{'h3FF, 'h7FF}, '{'hBFF, 'hFFF}};
    clen = '{'{512, 256}, '{256, 256}};
    apply_cfg();
    tbl[0] = '{1'b0, 11'd512, 11'd512, 2'b00, 2'b11, 11'd0, 11'd0, 2'b00, 24'h0, 2'b00, 24'h0};
    tbl[1] = '{1'b1, 11'd512, 11'd0, 2'b00, 2'b00, 11'd0, 11'd0, 2'b01, 24'h0, 2'b00, 24'h0};
    tbl[2] = '{1'b1, 11'd0, 11'd600, 2'b00, 2'b11, 11'd0, 11'd0, 2'b10, 24'h400, 2'b01, 24'h800};
    tbl[3] = '{1'b1, 11'd512, 11'd512, 2'b00, 2'b10, 11'd0, 11'd0, 2'b01, 24'h0, 2'b10, 24'hC00};
    tbl[4] = '{1'b1, 11'd511, 11'd512, 2'b00, 2'b11, 11'd300, 11'd0, 2'b10, 24'h400, 2'b10, 24'hC00};
    tbl[5] = '{1'b1, 11'd512, 11'd512, 2'b01, 2'b11, 11'd255, 11'd255, 2'b10, 24'h400, 2'b01, 24'h800};
    tbl[6] = '{1'b1, 11'd2047, 11'd2047, 2'b11, 2'b01, 11'd256, 11'd0, 2'b00, 24'h0, 2'b00, 24'h0};
    for (int r = 0; r < 7; r++) begin
      init = tbl[r].init;
      wr_level = {tbl[r].wl1, tbl[r].wl0};
      rd_level = {tbl[r].rl1, tbl[r].rl0};
      wr_load = tbl[r].wload;
      rd_valid = tbl[r].rvalid;
      rst_n = 1'b0;
      tick();
      chk($sformatf("row%0d_rst_wr_req", r), req_of(0), 0);
      chk($sformatf("row%0d_rst_rd_sel", r), sel_of(1), 0);
      rst_n = 1'b1;
      tick();
      chk($sformatf("row%0d_wr_req", r), req_of(0), 32'(|tbl[r].exp_wsel));
      chk($sformatf("row%0d_wr_sel", r), sel_of(0), 32'(tbl[r].exp_wsel));
      chk($sformatf("row%0d_wr_addr", r), 32'(bus.sdram_wr_addr), 32'(tbl[r].exp_waddr));
      chk($sformatf("row%0d_rd_req", r), req_of(1), 32'(|tbl[r].exp_rsel));
      chk($sformatf("row%0d_rd_sel", r), sel_of(1), 32'(tbl[r].exp_rsel));
      chk($sformatf("row%0d_rd_addr", r), 32'(bus.sdram_rd_addr), 32'(tbl[r].exp_raddr));
    end
    // single channel: advance then wrap
    wr_load = '0;
    rd_valid = '0;
    rd_level = '0;
    wr_level = {11'd0, 11'd512};
    init = 1'b1;
    rst_task();
    txn(0, 0, 'h000, 512);
    txn(0, 0, 'h200, 512);
    txn(0, 0, 'h000, 512);
    // round-robin alternation
    wr_level = {11'd512, 11'd512};
    rst_task();
    txn(0, 0, 'h000, 512);
    txn(0, 1, 'h400, 256);
    txn(0, 0, 'h200, 512);
    txn(0, 1, 'h500, 256);
    // load held through completion on the granted channel
    wr_level = {11'd512, 11'd0};
    txn_start(0, 1, 'h600, 256);
    set_ack(0, 1'b1);
    tick();
    wr_load = 2'b10;
    set_ack(0, 1'b0);
    tick();
    chk("load_sel_clear", sel_of(0), 0);
    wr_load = '0;
    txn(0, 1, 'h400, 256);
    wr_level = '0;
    // read side: disabled channel skipped, enabled mid-burst
    rd_valid = 2'b01;
    txn(1, 0, 'h800, 256);
    txn_start(1, 0, 'h900, 256);
    rd_valid = 2'b11;
    txn_end(1);
    txn(1, 1, 'hC00, 256);
    // concurrent write and read with coincident ack fall
    rd_valid = 2'b01;
    wr_level = {11'd0, 11'd512};
    txn_start(0, 0, 'h000, 512);
    txn_start(1, 0, 'hA00, 256);
    set_ack(0, 1'b1);
    set_ack(1, 1'b1);
    tick();
    chk("conc_wr_req_drop", req_of(0), 0);
    chk("conc_rd_req_drop", req_of(1), 0);
    set_ack(0, 1'b0);
    set_ack(1, 1'b0);
    tick();
    chk("conc_wr_sel_clear", sel_of(0), 0);
    chk("conc_rd_sel_clear", sel_of(1), 0);
    txn_start(0, 0, 'h200, 512);
    txn_start(1, 0, 'hB00, 256);
    // reset while both sides wait in REQ
    wr_level = {11'd512, 11'd512};
    rst_n = 1'b0;
    tick();
    chk("mid_rst_wr_req", req_of(0), 0);
    chk("mid_rst_rd_req", req_of(1), 0);
    chk("mid_rst_wr_sel", sel_of(0), 0);
    chk("mid_rst_wr_addr", 32'(bus.sdram_wr_addr), 0);
    rst_n = 1'b1;
    txn_start(0, 0, 'h000, 512);
    txn_start(1, 0, 'h800, 256);
    // randomized traffic against the transaction model
    rst_n = 1'b0;
    set_ack(0, 1'b0);
    set_ack(1, 1'b0);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 2; i++) begin
        cmin[s][i] = $urandom_range(0, 'h3000);
        cmax[s][i] = cmin[s][i] + $urandom_range(0, 'h200);
        clen[s][i] = $urandom_range(1, 100);
        ptr[s][i] = cmin[s][i];
      end
    apply_cfg();
    for (int s = 0; s < 2; s++) begin
      ph[s] = 0;
      rrp[s] = 0;
      pa[s] = 1'b0;
      wt[s] = 0;
      hd[s] = 0;
    end
    tick();
    rst_n = 1'b1;
    rand_inputs();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      model_side(0, wel(), wr_load, bus.sdram_wr_ack);
      model_side(1, rel(), rd_load, bus.sdram_rd_ack);
      check_side(0);
      check_side(1);
      drive_ack(0);
      drive_ack(1);
      rand_inputs();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Multi-channel successor to the single-port SDRAM FIFO control path. It arbitrates NUM_WR write channels and NUM_RD read channels onto the SDRAM controller's single write and single read request/ack port pair.
- Each channel has its own address window, burst length and reload.
- It sits between per-channel user FIFOs, which are instantiated outside it, and sdram_controller, all in the controller clock domain.
- It generates per-channel addresses with wrap-around and does round-robin grant with a one-hot select for the FIFO data muxes.

Parameters:
- NUM_WR, 2, number of write channels (1..8)
- NUM_RD, 2, number of read channels (1..8)
- ADDR_W, 24, SDRAM word address width
- LEN_W, 10, burst length width
- LVL_W, 11, FIFO fill-level width

Ports:
- clk  in  1  controller clock; single clock for the whole block
- rst_n  in  1  synchronous, active-low reset
- sdram_init_done  in  1  no request is issued while this is low
- wr_level  in  NUM_WR*LVL_W  words held in each write FIFO
- wr_min_addr / wr_max_addr  in  NUM_WR*ADDR_W each  per-channel window, inclusive
- wr_len  in  NUM_WR*LEN_W  per-channel burst length, must be >= 1
- wr_load  in  NUM_WR  per-channel reload
- rd_level  in  NUM_RD*LVL_W  words held in each read FIFO
- rd_valid  in  NUM_RD  per-channel read enable
- rd_min_addr / rd_max_addr / rd_len / rd_load  in  same widths as the write side
- sdram_wr_req  out  1; sdram_wr_ack  in  1
- sdram_wr_addr  out  ADDR_W; sdram_wr_burst  out  LEN_W
- wr_sel  out  NUM_WR  one-hot granted write channel, drives the FIFO read mux
- sdram_rd_req  out  1; sdram_rd_ack  in  1
- sdram_rd_addr  out  ADDR_W; sdram_rd_burst  out  LEN_W
- rd_sel  out  NUM_RD  one-hot granted read channel, drives the FIFO write demux

Behaviour:
- Reset (rst_n low at a clk edge):
  - all outputs clear to 0.
  - every channel address pointer loads its min_addr.
  - round-robin pointers go to channel 0.
  - FSMs go to IDLE.
  - Reset mid-burst abandons the burst with no pointer advance.
- Write side and read side are identical, independent FSMs. They may hold requests concurrently; the controller resolves priority between them.
- Eligibility, evaluated every cycle:
  - write channel i: init_done & !wr_load[i] & wr_level[i] >= wr_len[i].
  - read channel j: init_done & rd_valid[j] & !rd_load[j] & rd_level[j] < rd_len[j].
- FSM states:
  - IDLE: if any channel is eligible, grant the first eligible channel at or after the RR pointer, in cyclic order. Register sel, addr = ptr[g] and burst = len[g]. Assert req on the next cycle, giving 1-cycle latency. Go to REQ.
  - REQ: hold req, addr, burst and sel stable until ack=1. Then deassert req and go to BUSY. Eligibility changes in this state are ignored.
  - BUSY: sel held. On the ack falling edge (ack=0 with previous ack=1), update ptr[g], set RR pointer to g+1 mod N, clear sel and go to IDLE.
- Pointer update arithmetic uses ADDR_W+1 bits. With next = ptr + len: if next + len - 1 > max_addr, then ptr <= min_addr; else ptr <= next. A burst therefore never crosses max_addr.
- Load:
  - A load level forces ptr <= min_addr every cycle it is high and makes the channel ineligible.
  - Load on the granted channel during REQ/BUSY does not cancel the burst. At completion the pointer goes to min_addr; load wins over advance.
- Simultaneous ack completion on both sides: each side updates independently in the same cycle.
- Out-of-range configuration (min > max, or len = 0) is undefined; a checker assertion flags it.

Decomposition:
- Shared package sdram_pkg: the FSM state enum {IDLE, REQ, BUSY} and ADDR_W/LEN_W defaults, matching the existing SDRAM timing defines.
- One sub-module, sdram_chan_sched, instantiated twice (write and read). It contains the RR arbiter, FSM and per-channel pointer array, parametrised by channel count. The top handles per-side eligibility and wiring.

Test Plan:
- Reset then init_done=1, wr_level[0]=512, wr_len=512, window 0..0x3FF: wr_req asserts 1 cycle later with addr=0, burst=512, wr_sel=01. After ack pulse, next grant is addr=0x200; after that it wraps to 0.
- Both write channels eligible continuously: grants alternate 0,1,0,1 across four bursts, and each channel's pointer advances only on its own completion.
- rd_valid[1]=0 with rd_level low on both channels: only channel 0 is granted. Set rd_valid[1]=1 mid-burst: channel 1 is granted on the next IDLE.
- wr_load[1] pulsed during channel 1 BUSY with ptr=0x600, min=0x400: the burst completes and the next channel 1 address is 0x400.
- Concurrent write and read requests, with acks overlapping and falling in the same cycle: both FSMs return to IDLE together and both pointers update.
- rst_n low while in REQ: req drops next cycle, pointers return to min, and the first post-reset grant goes to channel 0.
